radix_bist_checker: RTL and testbench

RADIX_BIST_CHECKER -- requirements
Module: radix_bist_checker

---
 rtl/radix_bist_pkg.sv | 18 +
 rtl/misr16.sv | 38 +++
 rtl/radix_bist_checker.sv | 134 +++++++++++++
 tb/tb_radix_bist_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/radix_bist_pkg.sv
// Shared types and MISR constants for the radix multiplier BIST result checker.
package radix_bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam logic [15:0] MISR_POLY = 16'h1021;

   // One MISR step: shift left, fold the feedback polynomial on MSB, mix in the new word.
   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
      return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
   endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; load has priority over shift.
module misr16
   import radix_bist_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        shift_en,
   input  logic [15:0] data_in,
   output logic [15:0] sig
);

   logic [15:0] sig_d;
   logic [15:0] sig_q;

   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = seed;
      end else if (shift_en) begin
         sig_d = misr_step(sig_q, data_in);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/radix_bist_checker.sv
// Compacts a fixed number of multiplier results into a MISR and compares the
// final signature against a golden value, with an inter-result timeout.
module radix_bist_checker
   import radix_bist_pkg::*;
#(
   parameter int unsigned N_PATTERNS = 16,
   parameter logic [15:0] GOLDEN_SIG = 16'h0000,
   parameter logic [15:0] SEED       = 16'hFFFF,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        is_tested,
   input  logic [15:0] result,
   input  logic        ready,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature,
   output logic [7:0]  count,
   output logic        timeout_err
);

   localparam logic [7:0] N_PAT      = 8'(N_PATTERNS);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_e     state_d, state_q;
   logic [7:0] count_d, count_q;
   logic [7:0] timer_d, timer_q;
   logic       done_d, done_q;
   logic       pass_d, pass_q;
   logic       timeout_err_d, timeout_err_q;
   logic       ready_q;
   logic       accept;
   logic       misr_load;
   logic       misr_shift;

   // Only a rising edge of the level-style ready counts, and only while collecting.
   assign accept = (state_q == COLLECT) && ready && !ready_q;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      timer_d       = timer_q;
      done_d        = done_q;
      pass_d        = pass_q;
      timeout_err_d = timeout_err_q;
      misr_load     = 1'b0;
      misr_shift    = 1'b0;
      if (!is_tested) begin
         state_d       = IDLE;
         timer_d       = 8'd0;
         done_d        = 1'b0;
         pass_d        = 1'b0;
         timeout_err_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = COLLECT;
               count_d   = 8'd0;
               timer_d   = 8'd0;
               misr_load = 1'b1;
            end
            COLLECT: begin
               // An accept on the timeout cycle wins and restarts the timer.
               if (accept) begin
                  misr_shift = 1'b1;
                  count_d    = count_q + 8'd1;
                  timer_d    = 8'd0;
                  if (count_q + 8'd1 == N_PAT) begin
                     state_d = COMPARE;
                  end
               end else if (timer_q == TIMER_LAST) begin
                  state_d       = DONE;
                  done_d        = 1'b1;
                  pass_d        = 1'b0;
                  timeout_err_d = 1'b1;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
            COMPARE: begin
               state_d       = DONE;
               done_d        = 1'b1;
               pass_d        = (signature == GOLDEN_SIG);
               timeout_err_d = 1'b0;
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         count_q       <= 8'd0;
         timer_q       <= 8'd0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         timer_q       <= timer_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         timeout_err_q <= timeout_err_d;
         ready_q       <= ready;
      end
   end

   misr16 #(
      .SEED(SEED)
   ) u_misr (
      .clk     (clock),
      .rst_n   (reset),
      .load    (misr_load),
      .seed    (SEED),
      .shift_en(misr_shift),
      .data_in (result),
      .sig     (signature)
   );

   assign done        = done_q;
   assign pass        = pass_q;
   assign count       = count_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_radix_bist_checker.sv
// Self-checking bench: vector table, directed corner sequences and a randomized run against a model.
module tb_radix_bist_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        is_tested = 1'b0;
   logic [15:0] result = 16'h0000;
   logic        ready = 1'b0;

   logic [3:0]  done_w;
   logic [3:0]  pass_w;
   logic [3:0]  tmo_w;
   logic [15:0] sig_w [4];
   logic [7:0]  cnt_w [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // a: single-pattern pass; b/c: two-pattern compaction, golden 3 vs 4; d: defaults, random run
   radix_bist_checker #(.N_PATTERNS(1), .GOLDEN_SIG(16'hFFF4), .SEED(16'h0000), .TIMEOUT(8)) u_a (
      .clock(clk), .reset(reset), .is_tested(is_tested), .result(result), .ready(ready),
      .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0]), .count(cnt_w[0]), .timeout_err(tmo_w[0]));
   radix_bist_checker #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0003), .SEED(16'h0000), .TIMEOUT(8)) u_b (
      .clock(clk), .reset(reset), .is_tested(is_tested), .result(result), .ready(ready),
      .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1]), .count(cnt_w[1]), .timeout_err(tmo_w[1]));
   radix_bist_checker #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0004), .SEED(16'h0000), .TIMEOUT(8)) u_c (
      .clock(clk), .reset(reset), .is_tested(is_tested), .result(result), .ready(ready),
      .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2]), .count(cnt_w[2]), .timeout_err(tmo_w[2]));
   radix_bist_checker u_d (
      .clock(clk), .reset(reset), .is_tested(is_tested), .result(result), .ready(ready),
      .done(done_w[3]), .pass(pass_w[3]), .signature(sig_w[3]), .count(cnt_w[3]), .timeout_err(tmo_w[3]));

   // Reference model for u_d: the run is the list of accepted results; signature is their fold.
   localparam int          M_N    = 16;
   localparam int          M_TO   = 64;
   localparam logic [15:0] M_SEED = 16'hFFFF;
   localparam logic [15:0] M_GOLD = 16'h0000;

   logic [15:0] accq [$];
   int          m_phase;   // 0 idle, 1 collecting, 2 last result taken, 3 finished
   int          m_gap;
   logic        m_prev;
   logic        m_done, m_pass, m_tmo;

   function automatic logic [15:0] model_sig();
      int s;
      s = int'(M_SEED);
      foreach (accq[i]) begin
         s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 32'h0) ^ int'(accq[i]);
      end
      return 16'(s);
   endfunction

   task automatic model_step();
      logic rise;
      if (!reset) begin
         accq.delete();
         m_phase = 0; m_gap = 0; m_prev = 1'b0;
         m_done = 1'b0; m_pass = 1'b0; m_tmo = 1'b0;
      end else begin
         rise = ready && !m_prev;
         if (!is_tested) begin
            m_phase = 0; m_done = 1'b0; m_pass = 1'b0; m_tmo = 1'b0;
         end else if (m_phase == 0) begin
            m_phase = 1; accq.delete(); m_gap = 0;
         end else if (m_phase == 1) begin
            if (rise) begin
               accq.push_back(result);
               m_gap = 0;
               if (accq.size() == M_N) m_phase = 2;
            end else if (m_gap == M_TO - 1) begin
               m_phase = 3; m_done = 1'b1; m_tmo = 1'b1; m_pass = 1'b0;
            end else begin
               m_gap++;
            end
         end else if (m_phase == 2) begin
            m_phase = 3; m_done = 1'b1; m_pass = (model_sig() == M_GOLD);
         end
         m_prev = ready;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        it;
      logic        rdy;
      logic [15:0] res;
      logic        done;
      logic [7:0]  cnt;
      logic [15:0] sig;
      logic        pass_b;
      logic        pass_c;
   } vec_t;

   vec_t tbl [14];
   int   mode;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 8'd1, 16'h0001, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 8'd2, 16'h0003, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 8'd2, 16'h0003, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 8'd2, 16'h0003, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 16'h0005, 1'b1, 8'd2, 16'h0003, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'd2, 16'h0003, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 16'h0007, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 16'h0007, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0};

      // Reset state
      reset = 1'b0; is_tested = 1'b1; ready = 1'b1; result = 16'h1234;
      tick(); tick();
      chk16("rst_sig_d", sig_w[3], 16'hFFFF);
      chk16("rst_sig_b", sig_w[1], 16'h0000);
      chk16("rst_cnt_d", 16'(cnt_w[3]), 16'h0000);
      chk1("rst_done_d", done_w[3], 1'b0);
      chk1("rst_pass_d", pass_w[3], 1'b0);
      chk1("rst_tmo_d", tmo_w[3], 1'b0);

      // Table: compaction, level ready, DONE hold, abort, coincident start edge
      reset = 1'b1; is_tested = 1'b0; ready = 1'b0; result = 16'h0000;
      tick();
      for (int i = 0; i < 14; i++) begin
         is_tested = tbl[i].it; ready = tbl[i].rdy; result = tbl[i].res;
         tick();
         chk1($sformatf("tbl%0d_done_b", i), done_w[1], tbl[i].done);
         chk1($sformatf("tbl%0d_done_c", i), done_w[2], tbl[i].done);
         chk16($sformatf("tbl%0d_cnt_b", i), 16'(cnt_w[1]), 16'(tbl[i].cnt));
         chk16($sformatf("tbl%0d_sig_b", i), sig_w[1], tbl[i].sig);
         chk16($sformatf("tbl%0d_sig_c", i), sig_w[2], tbl[i].sig);
         chk1($sformatf("tbl%0d_pass_b", i), pass_w[1], tbl[i].pass_b);
         chk1($sformatf("tbl%0d_pass_c", i), pass_w[2], tbl[i].pass_c);
      end

      // Single pass on u_a: done two edges after the sampled rise
      is_tested = 1'b0; ready = 1'b0; tick();
      is_tested = 1'b1; tick();
      ready = 1'b1; result = 16'hFFF4; tick();
      chk1("single_done_early", done_w[0], 1'b0);
      chk16("single_cnt", 16'(cnt_w[0]), 16'h0001);
      ready = 1'b0; tick();
      chk1("single_done", done_w[0], 1'b1);
      chk1("single_pass", pass_w[0], 1'b1);
      chk16("single_sig", sig_w[0], 16'hFFF4);

      // Timeout on u_a: eight edges after the start edge
      is_tested = 1'b0; tick();
      is_tested = 1'b1; tick();
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk1($sformatf("tmo_done_%0d", i), done_w[0], (i == 8));
         chk1($sformatf("tmo_err_%0d", i), tmo_w[0], (i == 8));
      end
      chk1("tmo_pass", pass_w[0], 1'b0);

      // Accept on the would-be timeout cycle (u_b), then the timer restarts
      is_tested = 1'b0; tick();
      is_tested = 1'b1; tick();
      for (int i = 1; i <= 7; i++) tick();
      chk1("late_pre_done", done_w[1], 1'b0);
      ready = 1'b1; result = 16'h0001; tick();
      chk16("late_cnt", 16'(cnt_w[1]), 16'h0001);
      chk1("late_no_tmo", tmo_w[1], 1'b0);
      chk1("late_no_done", done_w[1], 1'b0);
      ready = 1'b0;
      for (int i = 1; i <= 7; i++) tick();
      chk1("restart_no_done", done_w[1], 1'b0);
      tick();
      chk1("restart_tmo", tmo_w[1], 1'b1);
      chk1("restart_done", done_w[1], 1'b1);

      // Randomized run on u_d against the model
      mode = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 150 == 0) mode = int'($urandom_range(0, 2));
         reset     = ($urandom_range(0, 599) != 0);
         is_tested = ($urandom_range(0, 149) != 0);
         case (mode)
            0:       ready = 1'($urandom_range(0, 1));
            1:       ready = ($urandom_range(0, 7) == 0);
            default: ready = 1'b0;
         endcase
         result = 16'($urandom);
         tick();
         chk16("rnd_sig", sig_w[3], model_sig());
         chk16("rnd_cnt", 16'(cnt_w[3]), 16'(accq.size()));
         chk1("rnd_done", done_w[3], m_done);
         chk1("rnd_pass", pass_w[3], m_pass);
         chk1("rnd_tmo", tmo_w[3], m_tmo);
      end

      // Reset in the middle of a run on u_d
      reset = 1'b1; is_tested = 1'b0; ready = 1'b0; tick();
      is_tested = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         ready = 1'b1; result = 16'h00A5 + 16'(i); tick();
         ready = 1'b0; tick();
      end
      chk16("mid_cnt_before", 16'(cnt_w[3]), 16'h0003);
      reset = 1'b0; ready = 1'b1; tick();
      chk16("mid_rst_sig", sig_w[3], 16'hFFFF);
      chk16("mid_rst_cnt", 16'(cnt_w[3]), 16'h0000);
      chk1("mid_rst_done", done_w[3], 1'b0);
      chk1("mid_rst_tmo", tmo_w[3], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
